accel_display_sampler: RTL

//  Sits directly upstream of the signed-to-BCD/7-segment converter. Accepts raw signed

---
 rtl/accel_display_sampler_pkg.sv | 15 +
 rtl/accel_display_sampler_if.sv | 25 ++
 rtl/accel_display_sampler_tick_divider.sv | 22 ++
 rtl/accel_display_sampler.sv | 101 ++++++++++
 4 files changed

// File: rtl/accel_display_sampler_pkg.sv
// Shared display limits and sampler FSM states for the accelerometer display path.
package accel_disp_pkg;

  localparam int DISP_W   = 10;
  localparam int DISP_MAX = 511;
  localparam int DISP_MIN = -511;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    COMMIT = 2'd1,
    VALID  = 2'd2,
    STALE  = 2'd3
  } state_t;

endpackage

// File: rtl/accel_display_sampler_if.sv
// Sample handshake plus converter-facing display signals of the accelerometer sampler.
interface accel_display_sampler_if #(
  parameter int IN_W = 16
);
  import accel_disp_pkg::*;

  logic              sample_valid;
  logic [IN_W-1:0]   sample_data;
  logic              sample_ready;
  logic              hold;
  logic [DISP_W-1:0] bin;
  logic              nothing;
  logic              update;

  modport master (
    output sample_valid, sample_data, hold,
    input  sample_ready, bin, nothing, update
  );

  modport slave (
    input  sample_valid, sample_data, hold,
    output sample_ready, bin, nothing, update
  );

endinterface

// File: rtl/accel_display_sampler_tick_divider.sv
// Free-running 0..DIV-1 counter producing a one-cycle tick at terminal count.
module tick_divider #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_cnt <= '0;
    else if (r_cnt == CW'(DIV - 1))  r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/accel_display_sampler.sv
// Block-averages signed samples, saturates to a symmetric 10-bit display value and
// reloads it at the refresh rate; flags "nothing" while no fresh average exists.
module accel_display_sampler
  import accel_disp_pkg::*;
#(
  parameter int          IN_W        = 16,
  parameter int          AVG_LOG2    = 3,
  parameter int unsigned REFRESH_DIV = 12_500_000,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input logic                    clk,
  input logic                    reset,
  accel_display_sampler_if.slave bus
);

  localparam int ACC_W = IN_W + AVG_LOG2;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc, r_avg, w_sum;
  logic signed [IN_W-1:0]   w_sample;
  logic [AVG_LOG2-1:0]      r_cnt;
  logic [TO_W-1:0]          r_to;
  logic                     r_ready, r_nothing, r_update;
  logic [DISP_W-1:0]        r_bin, w_clamped;
  logic                     w_accept, w_done, w_timeout, w_tick;

  tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign w_sample  = bus.sample_data;
  assign w_accept  = bus.sample_valid & r_ready;
  assign w_sum     = r_acc + ACC_W'(w_sample);
  assign w_done    = w_accept && (r_cnt == '1);
  // An accept in the timeout cycle clears the counter, so it suppresses the timeout.
  assign w_timeout = !w_accept && (r_to == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_done) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = VALID;
      VALID:   if (w_done) w_state_nxt = COMMIT;
               else if (w_timeout) w_state_nxt = STALE;
      STALE:   if (w_done) w_state_nxt = COMMIT;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    w_clamped = r_avg[DISP_W-1:0];
    if (r_avg > $signed(ACC_W'(DISP_MAX)))      w_clamped = DISP_W'(DISP_MAX);
    else if (r_avg < $signed(ACC_W'(DISP_MIN))) w_clamped = DISP_W'(DISP_MIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_acc     <= '0;
      r_avg     <= '0;
      r_cnt     <= '0;
      r_to      <= '0;
      r_ready   <= 1'b0;
      r_bin     <= '0;
      r_nothing <= 1'b1;
      r_update  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != COMMIT);

      if (w_accept)                     r_to <= '0;
      else if (r_to != TO_W'(TIMEOUT_CYC)) r_to <= r_to + 1'b1;

      if (w_done || w_timeout) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_done) r_avg <= w_sum >>> AVG_LOG2;

      r_update <= 1'b0;
      if (w_tick && !bus.hold) begin
        r_bin     <= w_clamped;
        r_nothing <= (r_state == EMPTY) || (r_state == STALE);
        r_update  <= 1'b1;
      end
    end
  end

  assign bus.sample_ready = r_ready;
  assign bus.bin          = r_bin;
  assign bus.nothing      = r_nothing;
  assign bus.update       = r_update;

endmodule
